// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Round-robin arbiter sitting directly in front of a combinational 2:1 word
// mux. It picks one of two valid/ready sources, drives the mux select, and
// captures the mux output into a one-entry registered output stage. That
// stage is presented downstream with a valid/ready handshake.
//
// Optional feature: define MUX_SEL_ARB_CNT_EN to enable the saturating
// per-source grant counters. When it is undefined, cnt1/cnt2 are tied to 0.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   in1_valid  in   source 1 offers a word on mux IN1
//   in1_ready  out  source 1 word consumed this cycle
//   in2_valid  in   source 2 offers a word on mux IN2
//   in2_ready  out  source 2 word consumed this cycle
//   sel        out  mux select (0 = IN1, 1 = IN2)
//   mux_out    in   mux output, returned combinationally
//   out_data   out  registered word to downstream
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   cnt1       out  grants to source 1 (feature only, else 0)
//   cnt2       out  grants to source 2 (feature only, else 0)
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in1_valid,
  output logic                   in1_ready,
  input  logic                   in2_valid,
  output logic                   in2_ready,
  output logic                   sel,
  input  logic [DATA_WIDTH-1:0]  mux_out,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] cnt1,
  output logic [COUNT_WIDTH-1:0] cnt2
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // last_sel uses select encoding: 1 means IN2 was served last. Resetting it
  // to 1 makes IN1 win the first tie and parks the idle select at 1.
  logic [0:0]            state_q, state_d;
  logic                  last_sel_q, last_sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic gnt_any;
  logic gnt_sel;
  logic can_load;
  logic xfer;

  // Grant is recomputed every cycle and is never locked.
  always_comb begin
    gnt_any = in1_valid | in2_valid;
    if (in1_valid && in2_valid) begin
      gnt_sel = ~last_sel_q;
    end else if (in2_valid) begin
      gnt_sel = 1'b1;
    end else if (in1_valid) begin
      gnt_sel = 1'b0;
    end else begin
      gnt_sel = last_sel_q;
    end
  end

  // A full stage that is draining this cycle can take a new word at once.
  assign can_load  = (state_q == EMPTY) | out_ready;
  assign sel       = gnt_sel;
  assign in1_ready = can_load & gnt_any & ~gnt_sel;
  assign in2_ready = can_load & gnt_any &  gnt_sel;
  assign xfer      = (in1_valid & in1_ready) | (in2_valid & in2_ready);

  always_comb begin
    state_d    = state_q;
    last_sel_d = last_sel_q;
    data_d     = data_q;
    if (xfer) begin
      state_d    = FULL;
      last_sel_d = gnt_sel;
      data_d     = mux_out;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      last_sel_q <= 1'b1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_sel_q <= last_sel_d;
      data_q     <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;

`ifdef MUX_SEL_ARB_CNT_EN
  logic [COUNT_WIDTH-1:0] cnt1_q, cnt1_d;
  logic [COUNT_WIDTH-1:0] cnt2_q, cnt2_d;

  // Counters stop at all-ones rather than wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (in1_valid && in1_ready) begin
      cnt1_d = sat_inc(cnt1_q);
    end
    if (in2_valid && in2_ready) begin
      cnt2_d = sat_inc(cnt2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`else
  assign cnt1 = '0;
  assign cnt2 = '0;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
//
// Directed table of per-cycle vectors. Each entry gives the inputs for one
// cycle together with the outputs expected before that cycle's rising edge.
// The mux is modelled here as a plain 2:1 select on the bench's source words.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in1_valid, in2_valid, out_ready;
  logic          in1_ready, in2_ready, sel, out_valid;
  logic [DW-1:0] d1, d2, mux_out, out_data;
  logic [CW-1:0] cnt1, cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mux_out = sel ? d2 : d1;

  mux_sel_arbiter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in2_valid (in2_valid),
    .in2_ready (in2_ready),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  typedef struct {
    logic          rst;
    logic          v1;
    logic          v2;
    logic          ordy;
    logic          esel;
    logic          er1;
    logic          er2;
    logic          eov;
    logic [DW-1:0] eod;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v1, input logic v2, input logic ordy,
                     input logic esel, input logic er1, input logic er2,
                     input logic eov, input logic [DW-1:0] eod);
    vec_t v;
    v.rst = r; v.v1 = v1; v.v2 = v2; v.ordy = ordy;
    v.esel = esel; v.er1 = er1; v.er2 = er2; v.eov = eov; v.eod = eod;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  localparam logic [DW-1:0] WA = 32'hA5A5_0001;
  localparam logic [DW-1:0] W1 = 32'h1111_1111;
  localparam logic [DW-1:0] W2 = 32'h2222_2222;

  initial begin
    rst = 1'b1; in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b0;
    d1 = WA; d2 = W2;

    //     rst v1 v2 ordy  sel r1 r2 ov  od
    // Idle after reset: select parked at 1, nothing ready.
    add(0, 0, 0, 1,   1, 0, 0, 0, '0);   // 0
    // Single source 1 transfer, then drain.
    add(0, 1, 0, 1,   0, 1, 0, 0, '0);   // 1
    add(0, 0, 0, 1,   0, 0, 0, 1, WA);   // 2
    add(0, 0, 0, 1,   0, 0, 0, 0, WA);   // 3  empty, data held
    // Reset so the alternation run starts from a fresh tie.
    add(1, 0, 0, 1,   0, 0, 0, 0, WA);   // 4
    // Sustained both-valid: strict 1,2,1,2 with no gaps.
    add(0, 1, 1, 1,   0, 1, 0, 0, '0);   // 5
    add(0, 1, 1, 1,   1, 0, 1, 1, W1);   // 6
    add(0, 1, 1, 1,   0, 1, 0, 1, W2);   // 7
    add(0, 1, 1, 1,   1, 0, 1, 1, W1);   // 8
    add(0, 1, 1, 1,   0, 1, 0, 1, W2);   // 9
    add(0, 1, 1, 1,   1, 0, 1, 1, W1);   // 10
    // Backpressure while full: both ready low, data held.
    add(0, 1, 1, 0,   0, 0, 0, 1, W2);   // 11
    add(0, 1, 1, 0,   0, 0, 0, 1, W2);   // 12
    add(0, 1, 1, 0,   0, 0, 0, 1, W2);   // 13
    add(0, 1, 1, 0,   0, 0, 0, 1, W2);   // 14
    // Release: next grant goes to IN1 after IN2 was last.
    add(0, 1, 1, 1,   0, 1, 0, 1, W2);   // 15
    // Reset while full and IN2 granted: word dropped.
    add(1, 1, 1, 1,   1, 0, 1, 1, W1);   // 16
    // First tie after reset goes to IN1 (empty stage loads despite ordy=0).
    add(0, 1, 1, 0,   0, 1, 0, 0, '0);   // 17
    add(0, 0, 1, 0,   1, 0, 0, 1, W1);   // 18 full, blocked
    add(0, 0, 1, 1,   1, 0, 1, 1, W1);   // 19 drain + load
    add(0, 0, 0, 0,   1, 0, 0, 1, W2);   // 20 idle sel stays at IN2
    add(0, 0, 0, 1,   1, 0, 0, 1, W2);   // 21 drain to empty
    add(0, 1, 0, 0,   0, 1, 0, 0, W2);   // 22
    add(0, 0, 0, 1,   0, 0, 0, 1, W1);   // 23

    // Two-cycle reset before the table.
    repeat (2) @(posedge clk);
    d1 = W1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      in1_valid = vecs[i].v1;
      in2_valid = vecs[i].v2;
      out_ready = vecs[i].ordy;
      if (i < 4) d1 = WA; else d1 = W1;
      #1;
      check("sel",       i, {31'd0, sel},       {31'd0, vecs[i].esel});
      check("in1_ready", i, {31'd0, in1_ready}, {31'd0, vecs[i].er1});
      check("in2_ready", i, {31'd0, in2_ready}, {31'd0, vecs[i].er2});
      check("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].eov});
      check("out_data",  i, out_data,           vecs[i].eod);
      if (in1_ready && in2_ready) check("one_ready", i, 32'd1, 32'd0);
      @(posedge clk);
    end

    @(negedge clk);
    rst = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b1;
    #1;
`ifdef MUX_SEL_ARB_CNT_EN
    // Since the reset at vector 16: IN1 transfers at 17 and 22, IN2 at 19.
    check("cnt1", 99, {16'd0, cnt1}, 32'd2);
    check("cnt2", 99, {16'd0, cnt2}, 32'd1);
`else
    check("cnt1", 99, {16'd0, cnt1}, 32'd0);
    check("cnt2", 99, {16'd0, cnt2}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
